// File: rtl/lsu_pkg.sv
// ============================================================================
// Module   : lsu_pkg
// Brief    : Shared types and helpers for the LSU data-memory port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B   = 2'd0,
    SZ_H   = 2'd1,
    SZ_W   = 2'd2,
    SZ_ILL = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC1 = 3'd1,
    ACC2 = 3'd2,
    CAP  = 3'd3,
    RESP = 3'd4
  } state_e;

  function automatic logic [3:0] byte_mask(input size_e sz);
    case (sz)
      SZ_B:    byte_mask = 4'b0001;
      SZ_H:    byte_mask = 4'b0011;
      default: byte_mask = 4'b1111;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_lane_align.sv
// ============================================================================
// Module   : lsu_lane_align
// Brief    : Combinational store lane shifting and load extraction/extension.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_off,
  input  size_e       i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [23:0] i_hi,
  input  logic [31:0] i_lo,
  output logic [3:0]  o_wren_lo,
  output logic [31:0] o_wdata_lo,
  output logic [3:0]  o_wren_hi,
  output logic [31:0] o_wdata_hi,
  output logic [31:0] o_rdata
);

  logic [3:0]  w_mask;
  logic [2:0]  w_sh_hi;
  logic [31:0] w_t;
  logic        w_sign_b;
  logic        w_sign_h;

  assign w_mask  = byte_mask(i_size);
  assign w_sh_hi = 3'd4 - {1'b0, i_off};

  assign o_wren_lo  = w_mask << i_off;
  assign o_wdata_lo = i_wdata << {i_off, 3'b000};
  assign o_wren_hi  = w_mask >> w_sh_hi;
  assign o_wdata_hi = i_wdata >> {w_sh_hi, 3'b000};

  // The top byte of the high word can never land in a 4-byte window.
  always_comb begin
    case (i_off)
      2'd0:    w_t = i_lo;
      2'd1:    w_t = {i_hi[7:0],  i_lo[31:8]};
      2'd2:    w_t = {i_hi[15:0], i_lo[31:16]};
      default: w_t = {i_hi[23:0], i_lo[31:24]};
    endcase
  end

  assign w_sign_b = ~i_unsigned & w_t[7];
  assign w_sign_h = ~i_unsigned & w_t[15];

  always_comb begin
    o_rdata = '0;
    case (i_size)
      SZ_B:    o_rdata = {{24{w_sign_b}}, w_t[7:0]};
      SZ_H:    o_rdata = {{16{w_sign_h}}, w_t[15:0]};
      SZ_W:    o_rdata = w_t;
      default: o_rdata = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_dmem_port.sv
// ============================================================================
// Module   : lsu_dmem_port
// Brief    : Byte-addressed load/store initiator for one port of the 64 KiB RAM.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsu_dmem_port
  import lsu_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [15:0] i_req_addr,
  input  logic        i_req_we,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic [15:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wren,
  input  logic [31:0] i_mem_rdata
);

  state_e      r_state;
  logic [15:0] r_addr;
  logic        r_we;
  size_e       r_size;
  logic        r_unsigned;
  logic [31:0] r_wdata;
  logic        r_cross;
  logic [31:0] r_lo;
  logic [23:0] r_hi;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;

  logic [13:0] w_word;
  logic [13:0] w_word_nxt;
  logic [3:0]  w_req_nb;
  logic        w_req_cross;
  logic        w_req_ill;
  logic [3:0]  w_wren_lo;
  logic [3:0]  w_wren_hi;
  logic [31:0] w_wdata_lo;
  logic [31:0] w_wdata_hi;
  logic [23:0] w_align_hi;
  logic [31:0] w_align_lo;
  logic [31:0] w_load_data;

  assign w_word      = r_addr[15:2];
  assign w_word_nxt  = w_word + 14'd1;
  assign w_req_ill   = (i_req_size == 2'd3);
  assign w_req_nb    = 4'd1 << i_req_size;
  assign w_req_cross = !w_req_ill && (({2'b00, i_req_addr[1:0]} + w_req_nb) > 4'd4);

  // In CAP the word arriving this cycle is merged directly with the held one.
  assign w_align_hi = r_cross ? i_mem_rdata[23:0] : r_hi;
  assign w_align_lo = r_cross ? r_lo : i_mem_rdata;

  lsu_lane_align u_align (
    .i_off      (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_unsigned),
    .i_wdata    (r_wdata),
    .i_hi       (w_align_hi),
    .i_lo       (w_align_lo),
    .o_wren_lo  (w_wren_lo),
    .o_wdata_lo (w_wdata_lo),
    .o_wren_hi  (w_wren_hi),
    .o_wdata_hi (w_wdata_hi),
    .o_rdata    (w_load_data)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_we        <= 1'b0;
      r_size      <= SZ_B;
      r_unsigned  <= 1'b0;
      r_wdata     <= '0;
      r_cross     <= 1'b0;
      r_lo        <= '0;
      r_hi        <= '0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_req_valid) begin
            r_addr      <= i_req_addr;
            r_we        <= i_req_we;
            r_size      <= size_e'(i_req_size);
            r_unsigned  <= i_req_unsigned;
            r_wdata     <= i_req_wdata;
            r_cross     <= w_req_cross;
            r_rsp_rdata <= '0;
            r_rsp_err   <= w_req_ill;
            r_state     <= w_req_ill ? RESP : ACC1;
          end
        end
        ACC1: begin
          if (r_cross)   r_state <= ACC2;
          else if (r_we) r_state <= RESP;
          else           r_state <= CAP;
        end
        ACC2: begin
          if (r_we) begin
            r_state <= RESP;
          end else begin
            r_lo    <= i_mem_rdata;
            r_state <= CAP;
          end
        end
        CAP: begin
          if (r_cross) r_hi <= i_mem_rdata[23:0];
          else         r_lo <= i_mem_rdata;
          r_rsp_rdata <= w_load_data;
          r_state     <= RESP;
        end
        RESP: begin
          if (i_rsp_ready) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_mem_addr  = '0;
    o_mem_wren  = '0;
    o_mem_wdata = '0;
    case (r_state)
      ACC1: begin
        o_mem_addr = {w_word, 2'b00};
        if (r_we) begin
          o_mem_wren  = w_wren_lo;
          o_mem_wdata = w_wdata_lo;
        end
      end
      ACC2: begin
        o_mem_addr = {w_word_nxt, 2'b00};
        if (r_we) begin
          o_mem_wren  = w_wren_hi;
          o_mem_wdata = w_wdata_hi;
        end
      end
      default: ;
    endcase
  end

  assign o_req_ready = (r_state == IDLE);
  assign o_rsp_valid = (r_state == RESP);
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;

endmodule

`default_nettype wire
